rs_stream_encoder: RTL and testbench

- Symbol-serial, systematic RS(N=18,K=16) encoder over GF(2^5), primitive polynomial x^5+x^2+1.
- Generator polynomial g(x)=(x+α)(x+α^2)=x^2+6x+8. Syndromes S1=c(α) and S2=c(α^2) of every emitted codeword are zero.
- Sits upstream of RS_Decoder. It streams codeword symbols and also presents the assembled parallel codeword in RS_Decoder's bus layout.

---
 rtl/rs_stream_encoder_if.sv | 34 +++
 rtl/rs_stream_encoder.sv | 184 ++++++++++++++++++
 tb/tb_rs_stream_encoder.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_stream_encoder_if.sv
// Stream and parallel-codeword bus of the RS(18,16) stream encoder.
//
// Handshake semantics, both directions: a transfer happens on a rising clk
// edge where valid && ready are both high. The producer keeps valid and its
// payload (data, sop, eop) stable until that transfer. ready may depend
// combinationally on the other side's ready, never on valid.
// cw_valid is a single-cycle strobe with no back-pressure.
interface rs_stream_encoder_if #(
  parameter int SYMBOL_WIDTH = 5,
  parameter int N            = 18
);
  logic                      in_valid;
  logic                      in_ready;
  logic [SYMBOL_WIDTH-1:0]   in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SYMBOL_WIDTH-1:0]   out_data;
  logic                      out_sop;
  logic                      out_eop;
  logic                      cw_valid;
  logic [N*SYMBOL_WIDTH-1:0] cw_out;

  // Encoder side
  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop, cw_valid, cw_out
  );

  // Environment side: message source and codeword sink
  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop, cw_valid, cw_out
  );
endinterface

// File: rtl/rs_stream_encoder.sv
// Symbol-serial systematic RS(18,16) encoder over GF(2^5), x^5+x^2+1.
// g(x) = (x+a)(x+a^2) = x^2 + G1 x + G0. Message symbols pass straight
// through a one-deep output register, followed by the two parity symbols held
// in a two-stage LFSR. The codeword is also assembled in parallel (cw_out)
// and announced with a one-cycle cw_valid strobe.
module rs_stream_encoder #(
  parameter int SYMBOL_WIDTH = 5,
  parameter int N            = 18,
  parameter int K            = 16,
  parameter int G1           = 6,
  parameter int G0           = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  rs_stream_encoder_if.master    bus,
  output logic [1:0]             dbg_state_o
);

  localparam int CNT_W = $clog2(K);
  localparam int POS_W = $clog2(N);

  localparam logic [SYMBOL_WIDTH-1:0] G1_C     = SYMBOL_WIDTH'(G1);
  localparam logic [SYMBOL_WIDTH-1:0] G0_C     = SYMBOL_WIDTH'(G0);
  // Low-order terms of the field polynomial: x^5 reduces to x^2 + 1.
  localparam logic [SYMBOL_WIDTH-1:0] POLY_LOW = SYMBOL_WIDTH'(5);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(K - 1);
  localparam logic [POS_W-1:0]        POS_TOP  = POS_W'(N - 1);

  typedef enum logic [1:0] {
    ST_MSG  = 2'd0,
    ST_PAR1 = 2'd1,
    ST_PAR0 = 2'd2
  } state_t;

  // GF(2^5) multiply: shift-and-add with reduction by x^5 = x^2 + 1.
  function automatic logic [SYMBOL_WIDTH-1:0] gf_mul(
    input logic [SYMBOL_WIDTH-1:0] a,
    input logic [SYMBOL_WIDTH-1:0] b
  );
    logic [SYMBOL_WIDTH-1:0] acc;
    logic [SYMBOL_WIDTH-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYMBOL_WIDTH; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[SYMBOL_WIDTH-2:0], 1'b0} ^ (sh[SYMBOL_WIDTH-1] ? POLY_LOW : '0);
    end
    return acc;
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SYMBOL_WIDTH-1:0] r1_q, r1_d;
  logic [SYMBOL_WIDTH-1:0] r0_q, r0_d;
  logic                    out_valid_q, out_valid_d;
  logic [SYMBOL_WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_sop_q, out_sop_d;
  logic                    out_eop_q, out_eop_d;
  logic                    cw_valid_q, cw_valid_d;
  logic [SYMBOL_WIDTH-1:0] cw_q [N];
  logic [SYMBOL_WIDTH-1:0] cw_d [N];

  logic                    buf_free;
  logic                    in_xfer;
  logic [SYMBOL_WIDTH-1:0] fb;
  logic [SYMBOL_WIDTH-1:0] fb_g1;
  logic [SYMBOL_WIDTH-1:0] fb_g0;
  logic [POS_W-1:0]        msg_pos;

  // The output register may be (re)loaded when empty or draining this cycle.
  assign buf_free     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (state_q == ST_MSG) && buf_free;
  assign in_xfer      = bus.in_valid && bus.in_ready;

  // LFSR feedback: message symbol plus the high-order remainder term.
  assign fb      = bus.in_data ^ r1_q;
  assign fb_g1   = gf_mul(fb, G1_C);
  assign fb_g0   = gf_mul(fb, G0_C);
  // First message symbol lands at the top codeword position N-1.
  assign msg_pos = POS_TOP - POS_W'(cnt_q);

  // Next-state logic: message pass-through, then two parity emits.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r1_d        = r1_q;
    r0_d        = r0_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    cw_valid_d  = 1'b0;
    cw_d        = cw_q;

    // A symbol accepted downstream leaves the register unless replaced below.
    if (bus.out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      ST_MSG: begin
        if (in_xfer) begin
          out_valid_d  = 1'b1;
          out_data_d   = bus.in_data;
          out_sop_d    = (cnt_q == '0);
          out_eop_d    = 1'b0;
          cw_d[msg_pos] = bus.in_data;
          r1_d         = r0_q ^ fb_g1;
          r0_d         = fb_g0;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_PAR1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PAR1: begin
        if (buf_free) begin
          out_valid_d = 1'b1;
          out_data_d  = r1_q;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
          cw_d[1]     = r1_q;
          state_d     = ST_PAR0;
        end
      end
      ST_PAR0: begin
        if (buf_free) begin
          out_valid_d = 1'b1;
          out_data_d  = r0_q;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b1;
          cw_d[0]     = r0_q;
          r1_d        = '0;
          r0_d        = '0;
          // cw_d now holds every position, so the strobe aligns with it.
          cw_valid_d  = 1'b1;
          state_d     = ST_MSG;
        end
      end
      default: begin
        state_d = ST_MSG;
      end
    endcase
  end

  // State register with synchronous reset; an aborted frame is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_MSG;
      cnt_q       <= '0;
      r1_q        <= '0;
      r0_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      cw_valid_q  <= 1'b0;
      for (int j = 0; j < N; j++) cw_q[j] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r1_q        <= r1_d;
      r0_q        <= r0_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      cw_valid_q  <= cw_valid_d;
      for (int j = 0; j < N; j++) cw_q[j] <= cw_d[j];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.cw_valid  = cw_valid_q;
  assign dbg_state_o   = state_q;

  for (genvar g = 0; g < N; g++) begin : g_cw
    assign bus.cw_out[g*SYMBOL_WIDTH +: SYMBOL_WIDTH] = cw_q[g];
  end

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Directed bench for rs_stream_encoder: hand-computed parity vectors,
// back-to-back throughput, mid-frame reset, and randomized back-pressure
// frames checked against a syndrome-solving reference.
module tb_rs_stream_encoder;
  localparam int W = 5;
  localparam int N = 18;
  localparam int K = 16;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   obs_data_q[$];
  logic           obs_sop_q[$];
  logic           obs_eop_q[$];
  logic [N*W-1:0] cw_q[$];

  rs_stream_encoder_if #(.SYMBOL_WIDTH(W), .N(N)) bus ();

  rs_stream_encoder #(
    .SYMBOL_WIDTH(W), .N(N), .K(K), .G1(6), .G0(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Carry-less product then reduction by x^5+x^2+1.
  function automatic logic [W-1:0] gf_mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-2:0] p;
    logic [2*W-2:0] poly;
    p    = '0;
    poly = 9'b000100101;
    for (int i = 0; i < W; i++) if (b[i]) p = p ^ ({4'b0, a} << i);
    for (int i = 2*W-2; i >= W; i--) if (p[i]) p = p ^ (poly << (i - W));
    return p[W-1:0];
  endfunction

  // Solve p1*a + p0 = M(a), p1*a^2 + p0 = M(a^2) so both syndromes vanish.
  task automatic build_codeword(input logic [W-1:0] msg[K], output logic [W-1:0] cw[N]);
    logic [W-1:0] ea, eb, inv6, p1, p0;
    ea   = '0;
    eb   = '0;
    inv6 = '0;
    for (int k = 0; k < K; k++) begin
      ea = gf_mul_ref(ea, 5'd2) ^ msg[k];
      eb = gf_mul_ref(eb, 5'd4) ^ msg[k];
    end
    ea = gf_mul_ref(gf_mul_ref(ea, 5'd2), 5'd2);
    eb = gf_mul_ref(gf_mul_ref(eb, 5'd4), 5'd4);
    for (int y = 1; y < 32; y++) if (gf_mul_ref(5'd6, 5'(y)) == 5'd1) inv6 = 5'(y);
    p1 = gf_mul_ref(ea ^ eb, inv6);
    p0 = ea ^ gf_mul_ref(p1, 5'd2);
    for (int k = 0; k < K; k++) cw[k] = msg[k];
    cw[K]   = p1;
    cw[K+1] = p0;
  endtask

  // ---------------- monitor ----------------
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_sop, prev_eop;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data},
              {1'b1, prev_sop, prev_eop, prev_data});
      if (bus.out_valid && bus.out_ready) begin
        obs_data_q.push_back(bus.out_data);
        obs_sop_q.push_back(bus.out_sop);
        obs_eop_q.push_back(bus.out_eop);
      end
      if (bus.cw_valid) cw_q.push_back(bus.cw_out);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_sop   = bus.out_sop;
      prev_eop   = bus.out_eop;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [W-1:0] msg[K], input int n, input bit rnd, output int stalls);
    int i;
    int budget;
    i      = 0;
    budget = 0;
    stalls = 0;
    while (i < n && budget < 2000) begin
      @(negedge clk);
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = msg[i];
      end
      #1;
      if (bus.in_valid && bus.in_ready) i++;
      else if (bus.in_valid) stalls++;
      budget++;
    end
    check("accepted_count", i, n);
  endtask

  task automatic drain(input int n_sym, input bit rnd);
    int budget;
    budget = 0;
    while (obs_data_q.size() < n_sym && budget < 2000) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      budget++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("drain_count", obs_data_q.size() >= n_sym, 1);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_frame(input string tag, input logic [W-1:0] exp_sym[N]);
    logic [N*W-1:0] exp_cw, got_cw;
    logic [W-1:0]   exp_d, got_d;
    logic           got_s, got_e;
    exp_cw = '0;
    for (int s = 0; s < N; s++) begin
      exp_q.push_back(exp_sym[s]);
      exp_cw[(N-1-s)*W +: W] = exp_sym[s];
    end
    check({tag, "_len"}, obs_data_q.size() >= N, 1);
    for (int s = 0; s < N; s++) begin
      exp_d = exp_q.pop_front();
      got_d = '0;
      got_s = 1'b0;
      got_e = 1'b0;
      if (obs_data_q.size() > 0) begin
        got_d = obs_data_q.pop_front();
        got_s = obs_sop_q.pop_front();
        got_e = obs_eop_q.pop_front();
      end
      check($sformatf("%s_sym%0d", tag, s), {got_s, got_e, got_d},
            {(s == 0), (s == N-1), exp_d});
    end
    check({tag, "_cwcount"}, cw_q.size() >= 1, 1);
    got_cw = (cw_q.size() > 0) ? cw_q.pop_front() : '0;
    check({tag, "_cw"}, got_cw, exp_cw);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] msg[K];
    logic [W-1:0] msg2[K];
    logic [W-1:0] cw_exp[N];
    int           stalls;
    int           eop_cnt;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_state",     dbg_state, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data, 0);
    check("rst_sop_eop",   {bus.out_sop, bus.out_eop}, 0);
    check("rst_cw_valid",  bus.cw_valid, 0);
    check("rst_cw_out",    bus.cw_out, 0);
    check("rst_in_ready",  bus.in_ready, 1);

    // All-zero message: eighteen zero symbols, zero codeword.
    foreach (msg[i]) msg[i] = '0;
    foreach (cw_exp[i]) cw_exp[i] = '0;
    send_frame(msg, K, 1'b0, stalls);
    check("zero_stalls", stalls, 0);
    drain(N, 1'b0);
    check_frame("zero", cw_exp);

    // Two frames back to back: parity 6,8 then 10,24; only the two parity
    // cycles may hold off the second frame.
    foreach (msg[i]) msg[i] = '0;
    msg[15] = 5'd1;
    foreach (msg2[i]) msg2[i] = '0;
    msg2[15] = 5'd3;
    send_frame(msg, K, 1'b0, stalls);
    send_frame(msg2, K, 1'b0, stalls);
    check("b2b_stalls", stalls, 2);
    drain(2*N, 1'b0);
    foreach (cw_exp[i]) cw_exp[i] = '0;
    cw_exp[15] = 5'd1;
    cw_exp[16] = 5'd6;
    cw_exp[17] = 5'd8;
    check_frame("one", cw_exp);
    cw_exp[15] = 5'd3;
    cw_exp[16] = 5'd10;
    cw_exp[17] = 5'd24;
    check_frame("three", cw_exp);

    // m(x) = x: parity of x^3 mod g = 28x + 21.
    foreach (msg[i]) msg[i] = '0;
    msg[14] = 5'd1;
    send_frame(msg, K, 1'b0, stalls);
    drain(N, 1'b0);
    foreach (cw_exp[i]) cw_exp[i] = '0;
    cw_exp[14] = 5'd1;
    cw_exp[16] = 5'd28;
    cw_exp[17] = 5'd21;
    check_frame("xpow1", cw_exp);

    // Reset after the 7th symbol, then a clean frame.
    foreach (msg[i]) msg[i] = 5'(i + 1);
    send_frame(msg, 7, 1'b0, stalls);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_state",     dbg_state, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_cw_valid",  bus.cw_valid, 0);
    #3;
    eop_cnt = 0;
    foreach (obs_eop_q[i]) if (obs_eop_q[i]) eop_cnt++;
    check("abort_no_eop", eop_cnt, 0);
    check("abort_no_cw",  cw_q.size(), 0);
    obs_data_q.delete();
    obs_sop_q.delete();
    obs_eop_q.delete();
    foreach (msg[i]) msg[i] = '0;
    msg[15] = 5'd1;
    send_frame(msg, K, 1'b0, stalls);
    drain(N, 1'b0);
    foreach (cw_exp[i]) cw_exp[i] = '0;
    cw_exp[15] = 5'd1;
    cw_exp[16] = 5'd6;
    cw_exp[17] = 5'd8;
    check_frame("post_abort", cw_exp);

    // Random messages under random back-pressure and input gaps.
    for (int f = 0; f < 100; f++) begin
      foreach (msg[i]) msg[i] = 5'($urandom_range(0, 31));
      build_codeword(msg, cw_exp);
      send_frame(msg, K, 1'b1, stalls);
      drain(N, 1'b1);
      check_frame($sformatf("rnd%0d", f), cw_exp);
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
